nf10_nic_output_demux: RTL and testbench

//  Sits after the NIC output-port-lookup stage and consumes the DST_PORT bitmap it writes into tuser.

---
 rtl/nf10_nic_pkg.sv | 16 +
 rtl/nf10_axis_mcast_slot.sv | 50 +++++
 rtl/nf10_nic_output_demux.sv | 96 +++++++++
 tb/tb_nf10_nic_output_demux.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/nf10_nic_pkg.sv
// Shared NIC constants: tuser field positions, default port count and demux state encoding.
package nf10_nic_pkg;
  localparam int DST_PORT_POS      = 24;
  localparam int SRC_PORT_POS      = 16;
  localparam int NUM_PORTS_DEFAULT = 8;

  localparam logic [1:0] HEADER = 2'd0;
  localparam logic [1:0] FWD    = 2'd1;
  localparam logic [1:0] DROP   = 2'd2;

  typedef enum logic [1:0] {
    S_HEADER = HEADER,
    S_FWD    = FWD,
    S_DROP   = DROP
  } demux_state_t;
endpackage

// File: rtl/nf10_axis_mcast_slot.sv
// One-beat output register shared by all ports, with a pending mask of ports still owed the beat.
module nf10_axis_mcast_slot #(
  parameter int DATA_W = 256,
  parameter int USER_W = 128,
  parameter int NP     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [DATA_W-1:0]   load_data,
  input  logic [DATA_W/8-1:0] load_strb,
  input  logic [USER_W-1:0]   load_user,
  input  logic                load_last,
  input  logic [NP-1:0]       load_mask,
  input  logic [NP-1:0]       tready,
  output logic [DATA_W-1:0]   data,
  output logic [DATA_W/8-1:0] strb,
  output logic [USER_W-1:0]   user,
  output logic                last,
  output logic [NP-1:0]       tvalid,
  output logic                slot_valid,
  output logic                retire_now
);
  logic [NP-1:0] pend;
  logic [NP-1:0] pend_left;

  // The slot is occupied exactly while some port is still owed the beat.
  assign slot_valid = |pend;
  assign tvalid     = {NP{slot_valid}} & pend;
  assign pend_left  = pend & ~(tvalid & tready);
  assign retire_now = slot_valid & ~(|pend_left);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
      data <= '0;
      strb <= '0;
      user <= '0;
      last <= 1'b0;
    end else if (load) begin
      pend <= load_mask;
      data <= load_data;
      strb <= load_strb;
      user <= load_user;
      last <= load_last;
    end else begin
      pend <= pend_left;
    end
  end
endmodule

// File: rtl/nf10_nic_output_demux.sv
// Fans each AXI4-Stream packet out to the ports named by its first-beat DST_PORT bitmap; empty bitmaps are dropped.
module nf10_nic_output_demux
  import nf10_nic_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH = 256,
  parameter int C_USER_WIDTH      = 128,
  parameter int NUM_PORTS         = NUM_PORTS_DEFAULT,
  parameter int DST_PORT_POS      = nf10_nic_pkg::DST_PORT_POS
) (
  input  logic                           axi_aclk,
  input  logic                           axi_reset,
  input  logic [C_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb,
  input  logic [C_USER_WIDTH-1:0]        s_axis_tuser,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  input  logic                           s_axis_tlast,
  output logic [C_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic [C_USER_WIDTH-1:0]        m_axis_tuser,
  output logic                           m_axis_tlast,
  output logic [NUM_PORTS-1:0]           m_axis_tvalid,
  input  logic [NUM_PORTS-1:0]           m_axis_tready,
  output logic [31:0]                    pkt_fwd_cnt,
  output logic [31:0]                    pkt_drop_cnt
);
  demux_state_t         state;
  logic [NUM_PORTS-1:0] mask_q;
  logic [NUM_PORTS-1:0] mask_in;
  logic [NUM_PORTS-1:0] load_mask;
  logic                 slot_valid;
  logic                 retire_now;
  logic                 accept;
  logic                 load;
  logic                 drop_pkt;
  logic                 fwd_pkt;

  assign mask_in       = s_axis_tuser[DST_PORT_POS +: NUM_PORTS];
  assign s_axis_tready = (state == S_DROP) ? 1'b1 : (~slot_valid | retire_now);
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign load          = accept & (((state == S_HEADER) & (|mask_in)) | (state == S_FWD));
  assign load_mask     = (state == S_HEADER) ? mask_in : mask_q;
  assign fwd_pkt       = retire_now & m_axis_tlast;
  // A dropped packet is counted once, on its tlast, whether it is one beat or many.
  assign drop_pkt      = accept & s_axis_tlast &
                         ((state == S_DROP) | ((state == S_HEADER) & ~(|mask_in)));

  nf10_axis_mcast_slot #(
    .DATA_W (C_AXIS_DATA_WIDTH),
    .USER_W (C_USER_WIDTH),
    .NP     (NUM_PORTS)
  ) u_slot (
    .clk        (axi_aclk),
    .rst        (axi_reset),
    .load       (load),
    .load_data  (s_axis_tdata),
    .load_strb  (s_axis_tstrb),
    .load_user  (s_axis_tuser),
    .load_last  (s_axis_tlast),
    .load_mask  (load_mask),
    .tready     (m_axis_tready),
    .data       (m_axis_tdata),
    .strb       (m_axis_tstrb),
    .user       (m_axis_tuser),
    .last       (m_axis_tlast),
    .tvalid     (m_axis_tvalid),
    .slot_valid (slot_valid),
    .retire_now (retire_now)
  );

  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      state  <= S_HEADER;
      mask_q <= '0;
    end else if (accept) begin
      case (state)
        S_HEADER: begin
          mask_q <= mask_in;
          if (!s_axis_tlast) state <= (|mask_in) ? S_FWD : S_DROP;
        end
        S_FWD, S_DROP: if (s_axis_tlast) state <= S_HEADER;
        default: state <= S_HEADER;
      endcase
    end
  end

  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      pkt_fwd_cnt  <= '0;
      pkt_drop_cnt <= '0;
    end else begin
      if (fwd_pkt && pkt_fwd_cnt != 32'hFFFF_FFFF)   pkt_fwd_cnt  <= pkt_fwd_cnt + 32'd1;
      if (drop_pkt && pkt_drop_cnt != 32'hFFFF_FFFF) pkt_drop_cnt <= pkt_drop_cnt + 32'd1;
    end
  end
endmodule

// File: tb/tb_nf10_nic_output_demux.sv
// Directed bench for the NIC output demux: unicast, multicast skew, drop, mid-packet bitmap change, back-to-back, reset.
module tb_nf10_nic_output_demux;
  logic         axi_aclk = 1'b0;
  logic         axi_reset;
  logic [255:0] s_axis_tdata;
  logic [31:0]  s_axis_tstrb;
  logic [127:0] s_axis_tuser;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic         s_axis_tlast;
  logic [255:0] m_axis_tdata;
  logic [31:0]  m_axis_tstrb;
  logic [127:0] m_axis_tuser;
  logic         m_axis_tlast;
  logic [7:0]   m_axis_tvalid;
  logic [7:0]   m_axis_tready;
  logic [31:0]  pkt_fwd_cnt;
  logic [31:0]  pkt_drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 axi_aclk = ~axi_aclk;

  nf10_nic_output_demux dut (
    .axi_aclk      (axi_aclk),
    .axi_reset     (axi_reset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tstrb  (s_axis_tstrb),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tstrb  (m_axis_tstrb),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .pkt_fwd_cnt   (pkt_fwd_cnt),
    .pkt_drop_cnt  (pkt_drop_cnt)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Upper tuser bits carry junk so routing must use only the bitmap field.
  task automatic drive(input logic v, input logic [31:0] d, input logic [7:0] mask, input logic l);
    s_axis_tvalid = v;
    s_axis_tdata  = {8{d}};
    s_axis_tstrb  = 32'hFFFF_FFFF;
    s_axis_tuser  = {96'hDEAD_BEEF, mask, 24'h00_0000};
    s_axis_tlast  = l;
  endtask

  task automatic next_cycle();
    @(negedge axi_aclk);
    #1;
  endtask

  initial begin
    axi_reset     = 1'b1;
    m_axis_tready = 8'hFF;
    drive(1'b0, 32'h0, 8'h00, 1'b0);
    #12;
    check("rst_tvalid",  m_axis_tvalid, 8'h00);
    check("rst_fwd",     pkt_fwd_cnt,   32'd0);
    check("rst_drop",    pkt_drop_cnt,  32'd0);
    check("rst_data",    m_axis_tdata,  256'd0);
    check("rst_tready",  s_axis_tready, 1'b1);
    next_cycle();
    axi_reset = 1'b0;
    next_cycle();

    // 1: unicast 3 beats to port 0 on consecutive cycles
    drive(1'b1, 32'hA0, 8'h01, 1'b0);
    next_cycle();
    check("uc_b0_valid", m_axis_tvalid, 8'h01);
    check("uc_b0_data",  m_axis_tdata[31:0], 32'hA0);
    check("uc_b0_ready", s_axis_tready, 1'b1);
    drive(1'b1, 32'hA1, 8'h01, 1'b0);
    next_cycle();
    check("uc_b1_valid", m_axis_tvalid, 8'h01);
    check("uc_b1_data",  m_axis_tdata[31:0], 32'hA1);
    drive(1'b1, 32'hA2, 8'h01, 1'b1);
    next_cycle();
    check("uc_b2_valid", m_axis_tvalid, 8'h01);
    check("uc_b2_data",  m_axis_tdata[31:0], 32'hA2);
    check("uc_b2_last",  m_axis_tlast, 1'b1);
    drive(1'b0, 32'h0, 8'h00, 1'b0);
    next_cycle();
    check("uc_idle",     m_axis_tvalid, 8'h00);
    check("uc_fwd",      pkt_fwd_cnt, 32'd1);

    // 2: multicast to ports 0 and 2; port 2 stalls 4 cycles
    m_axis_tready = 8'hFB;
    drive(1'b1, 32'hB0, 8'h05, 1'b0);
    next_cycle();
    check("mc_b0_valid", m_axis_tvalid, 8'h05);
    check("mc_b0_data",  m_axis_tdata[31:0], 32'hB0);
    check("mc_b0_ready", s_axis_tready, 1'b0);
    drive(1'b1, 32'hB1, 8'h05, 1'b1);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      check("mc_stall_valid", m_axis_tvalid, 8'h04);
      check("mc_stall_data",  m_axis_tdata[31:0], 32'hB0);
      check("mc_stall_ready", s_axis_tready, 1'b0);
    end
    m_axis_tready = 8'hFF;
    #1;
    check("mc_release_ready", s_axis_tready, 1'b1);
    next_cycle();
    check("mc_b1_valid", m_axis_tvalid, 8'h05);
    check("mc_b1_data",  m_axis_tdata[31:0], 32'hB1);
    drive(1'b0, 32'h0, 8'h00, 1'b0);
    next_cycle();
    check("mc_fwd",      pkt_fwd_cnt, 32'd2);
    check("mc_idle",     m_axis_tvalid, 8'h00);

    // 3: 4-beat zero-bitmap packet dropped, then 1 beat to port 1
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'hC0 + 32'(i), 8'h00, i == 3);
      #1;
      check("drop_ready", s_axis_tready, 1'b1);
      next_cycle();
      check("drop_valid", m_axis_tvalid, 8'h00);
    end
    check("drop_cnt",    pkt_drop_cnt, 32'd1);
    drive(1'b1, 32'hC9, 8'h02, 1'b1);
    next_cycle();
    check("post_drop_valid", m_axis_tvalid, 8'h02);
    check("post_drop_data",  m_axis_tdata[31:0], 32'hC9);
    drive(1'b0, 32'h0, 8'h00, 1'b0);
    next_cycle();
    check("post_drop_fwd",  pkt_fwd_cnt, 32'd3);
    check("post_drop_drop", pkt_drop_cnt, 32'd1);

    // 4: later-beat bitmap ignored for routing, tuser forwarded unchanged
    drive(1'b1, 32'hD0, 8'h10, 1'b0);
    next_cycle();
    check("chg_b0_valid", m_axis_tvalid, 8'h10);
    drive(1'b1, 32'hD1, 8'h01, 1'b1);
    next_cycle();
    check("chg_b1_valid", m_axis_tvalid, 8'h10);
    check("chg_b1_user",  m_axis_tuser[31:24], 8'h01);
    drive(1'b0, 32'h0, 8'h00, 1'b0);
    next_cycle();
    check("chg_fwd", pkt_fwd_cnt, 32'd4);

    // 5: back-to-back single-beat packets, no bubbles
    drive(1'b1, 32'hE0, 8'h01, 1'b1);
    next_cycle();
    check("b2b_0_valid", m_axis_tvalid, 8'h01);
    check("b2b_0_data",  m_axis_tdata[31:0], 32'hE0);
    drive(1'b1, 32'hE1, 8'h02, 1'b1);
    next_cycle();
    check("b2b_1_valid", m_axis_tvalid, 8'h02);
    check("b2b_1_data",  m_axis_tdata[31:0], 32'hE1);
    drive(1'b1, 32'hE2, 8'h04, 1'b1);
    next_cycle();
    check("b2b_2_valid", m_axis_tvalid, 8'h04);
    check("b2b_2_data",  m_axis_tdata[31:0], 32'hE2);
    drive(1'b0, 32'h0, 8'h00, 1'b0);
    next_cycle();
    check("b2b_fwd", pkt_fwd_cnt, 32'd7);

    // 6: reset during beat 2 of a 5-beat packet
    drive(1'b1, 32'hF0, 8'h01, 1'b0);
    next_cycle();
    drive(1'b1, 32'hF1, 8'h01, 1'b0);
    next_cycle();
    check("rst_mid_pre", m_axis_tvalid, 8'h01);
    drive(1'b1, 32'hF2, 8'h01, 1'b0);
    axi_reset = 1'b1;
    #1;
    check("rst_mid_valid", m_axis_tvalid, 8'h00);
    check("rst_mid_fwd",   pkt_fwd_cnt,   32'd0);
    check("rst_mid_drop",  pkt_drop_cnt,  32'd0);
    drive(1'b0, 32'h0, 8'h00, 1'b0);
    next_cycle();
    axi_reset = 1'b0;
    next_cycle();
    drive(1'b1, 32'hF9, 8'h08, 1'b1);
    next_cycle();
    check("rst_next_valid", m_axis_tvalid, 8'h08);
    check("rst_next_data",  m_axis_tdata[31:0], 32'hF9);
    drive(1'b0, 32'h0, 8'h00, 1'b0);
    next_cycle();
    check("rst_next_fwd", pkt_fwd_cnt, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
